// File: rtl/lfsr_word_source_if.sv
// Control, status and valid/ready word bus between lfsr_word_source and its consumer.
// The lockup status line exists only when LFSR_LOCKUP_RECOVER_EN is defined.
interface lfsr_word_source_if #(
  parameter int WIDTH   = 40,
  parameter int COUNT_W = 4
);
  logic               seed_load;
  logic [WIDTH-1:0]   seed_in;
  logic               start;
  logic [COUNT_W-1:0] count;
  logic [WIDTH-1:0]   data_out;
  logic               data_valid;
  logic               data_ready;
  logic [COUNT_W-1:0] word_idx;
  logic               busy;
  logic               done;
`ifdef LFSR_LOCKUP_RECOVER_EN
  logic               lockup;
`endif

  modport master (
    input  seed_load, seed_in, start, count, data_ready,
`ifdef LFSR_LOCKUP_RECOVER_EN
    output lockup,
`endif
    output data_out, data_valid, word_idx, busy, done
  );

  modport slave (
    output seed_load, seed_in, start, count, data_ready,
`ifdef LFSR_LOCKUP_RECOVER_EN
    input  lockup,
`endif
    input  data_out, data_valid, word_idx, busy, done
  );
endinterface

// File: rtl/lfsr_word_source.sv
// Burst source of Fibonacci-LFSR words over valid/ready, with seed load and busy/done status.
// Optional LFSR_LOCKUP_RECOVER_EN: an all-zero state is replaced by DEFAULT_SEED and flagged on lockup.
module lfsr_word_source #(
  parameter int               WIDTH        = 40,
  parameter logic [WIDTH-1:0] TAPS         = 40'hA0_0014_0000,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 40'h00_0000_0001,
  parameter int               COUNT_W      = 4
) (
  input  logic                clk,
  input  logic                reset,
  lfsr_word_source_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t               r_fsm, w_fsm_nxt;
  logic [WIDTH-1:0]   r_state, w_state_nxt;
  logic [COUNT_W-1:0] r_len, w_len_nxt;
  logic [COUNT_W-1:0] r_idx, w_idx_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               w_fb;
  logic [WIDTH-1:0]   w_adv;
  logic               w_xfer;
`ifdef LFSR_LOCKUP_RECOVER_EN
  logic               r_lockup, w_lockup_nxt;
`endif

  assign w_fb   = ^(r_state & TAPS);
  assign w_adv  = {r_state[WIDTH-2:0], w_fb};
  assign w_xfer = r_valid && bus.data_ready;

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
    w_lockup_nxt = 1'b0;
`endif
    case (r_fsm)
      IDLE: begin
        if (bus.seed_load) w_state_nxt = bus.seed_in;
        if (bus.start && (bus.count != '0)) begin
          w_len_nxt   = bus.count;
          w_idx_nxt   = '0;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_fsm_nxt   = RUN;
        end
      end
      RUN: begin
        if (w_xfer) begin
          w_state_nxt = w_adv;
          if (r_idx == r_len - COUNT_W'(1)) begin
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_fsm_nxt   = DONE;
          end else begin
            w_idx_nxt = r_idx + COUNT_W'(1);
          end
        end
      end
      DONE: begin
        w_fsm_nxt = IDLE;
      end
      default: begin
        w_fsm_nxt   = IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
`ifdef LFSR_LOCKUP_RECOVER_EN
    // Zero is a fixed point of the shift; never let it become the presented word.
    if (w_state_nxt == '0) begin
      w_state_nxt  = DEFAULT_SEED;
      w_lockup_nxt = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fsm   <= IDLE;
      r_state <= DEFAULT_SEED;
      r_len   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
      r_lockup <= 1'b0;
`endif
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef LFSR_LOCKUP_RECOVER_EN
      r_lockup <= w_lockup_nxt;
`endif
    end
  end

  assign bus.data_out   = r_state;
  assign bus.data_valid = r_valid;
  assign bus.word_idx   = r_idx;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
`ifdef LFSR_LOCKUP_RECOVER_EN
  assign bus.lockup     = r_lockup;
`endif

endmodule
